hsv_core_commit_order: RTL and testbench



---
 rtl/hsv_core_pkg.sv | 18 +
 rtl/hsv_core_commit_order_if.sv | 29 ++
 rtl/hsv_core_commit_order_match.sv | 30 +++
 rtl/hsv_core_commit_order.sv | 135 +++++++++++++
 tb/tb_hsv_core_commit_order.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hsv_core_pkg.sv
// rtl/hsv_core_pkg.sv - shared types and constants for the core commit-order block
package hsv_core_pkg;
   localparam int NUM_EXEC_UNITS      = 5;
   localparam int COMMIT_DATA_W       = 64;
   localparam int COMMIT_TOKEN_W      = 2;
   localparam int STALL_LIMIT_DEFAULT = 1024;

   typedef logic [COMMIT_TOKEN_W-1:0] commit_token_t;

   // Execution unit index; lower index wins a (faulty) token tie.
   typedef enum logic [2:0] {
      ALU        = 3'd0,
      FOO        = 3'd1,
      MEM        = 3'd2,
      BRANCH     = 3'd3,
      CTRLSTATUS = 3'd4
   } unit_idx_e;
endpackage

// File: rtl/hsv_core_commit_order_if.sv
// rtl/hsv_core_commit_order_if.sv - unit result streams and the commit slot bundle
interface hsv_core_commit_order_if #(
   parameter int NUM_UNITS = 5,
   parameter int DATA_W    = 64,
   parameter int TOKEN_W   = 2
);
   localparam int UNIT_W = $clog2(NUM_UNITS);

   logic [NUM_UNITS-1:0]         unit_valid_i;
   logic [NUM_UNITS-1:0]         unit_ready_o;
   logic [NUM_UNITS*DATA_W-1:0]  unit_data_i;
   logic [NUM_UNITS*TOKEN_W-1:0] unit_token_i;
   logic                         out_valid_o;
   logic                         out_ready_i;
   logic [DATA_W-1:0]            out_data_o;
   logic [UNIT_W-1:0]            out_unit_o;

   // Execution units and commit stage side
   modport master (
      output unit_valid_i, unit_data_i, unit_token_i, out_ready_i,
      input  unit_ready_o, out_valid_o, out_data_o, out_unit_o
   );

   // Commit-order block side
   modport slave (
      input  unit_valid_i, unit_data_i, unit_token_i, out_ready_i,
      output unit_ready_o, out_valid_o, out_data_o, out_unit_o
   );
endinterface

// File: rtl/hsv_core_commit_order_match.sv
// rtl/hsv_core_commit_order_match.sv - combinational token matcher with lowest-index select
module hsv_core_commit_order_match
   import hsv_core_pkg::*;
#(
   parameter int NUM_UNITS = NUM_EXEC_UNITS,
   parameter int TOKEN_W   = COMMIT_TOKEN_W,
   parameter int UNIT_W    = $clog2(NUM_UNITS)
) (
   input  logic [NUM_UNITS-1:0]         valid_i,
   input  logic [NUM_UNITS*TOKEN_W-1:0] token_i,
   input  logic [TOKEN_W-1:0]           expect_i,
   output logic [NUM_UNITS-1:0]         match_o,
   output logic [UNIT_W-1:0]            sel_o,
   output logic                         any_match_o,
   output logic                         multi_match_o
);
   // Per-unit match; scanning downward leaves the lowest matching index in sel_o
   always_comb begin
      match_o = '0;
      sel_o   = '0;
      for (int i = NUM_UNITS - 1; i >= 0; i--) begin
         match_o[i] = valid_i[i] & (token_i[i*TOKEN_W +: TOKEN_W] == expect_i);
         if (match_o[i]) sel_o = UNIT_W'(i);
      end
   end

   assign any_match_o   = |match_o;
   // Clearing the lowest set bit leaves something only if two or more matched
   assign multi_match_o = |(match_o & (match_o - NUM_UNITS'(1)));
endmodule

// File: rtl/hsv_core_commit_order.sv
// rtl/hsv_core_commit_order.sv - in-order forwarding of unit results to the commit slot
module hsv_core_commit_order
   import hsv_core_pkg::*;
#(
   parameter int NUM_UNITS   = NUM_EXEC_UNITS,
   parameter int DATA_W      = COMMIT_DATA_W,
   parameter int TOKEN_W     = COMMIT_TOKEN_W,
   parameter int STALL_LIMIT = STALL_LIMIT_DEFAULT
) (
   input  logic                     clk_core,
   input  logic                     rst_core,
   input  logic                     flush_req,
   output logic                     flush_ack,
   hsv_core_commit_order_if.slave   bus,
   output logic [TOKEN_W-1:0]       commit_token_o,
   output logic                     retire_o,
   output logic                     order_err_o
);
   localparam int UNIT_W  = $clog2(NUM_UNITS);
   localparam int STALL_W = $clog2(STALL_LIMIT + 1);

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   logic [0:0]         state_q, state_d;
   logic               out_valid_q, out_valid_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic [UNIT_W-1:0]  out_unit_q, out_unit_d;
   logic [TOKEN_W-1:0] token_q, token_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               err_q, err_d;
   logic               flush_ack_q, flush_ack_d;

   logic [NUM_UNITS-1:0] match;
   logic [UNIT_W-1:0]    sel;
   logic                 any_match;
   logic                 multi_match;
   logic                 run_open;
   logic                 free;
   logic                 accept;

   hsv_core_commit_order_match #(
      .NUM_UNITS (NUM_UNITS),
      .TOKEN_W   (TOKEN_W),
      .UNIT_W    (UNIT_W)
   ) u_match (
      .valid_i       (bus.unit_valid_i),
      .token_i       (bus.unit_token_i),
      .expect_i      (token_q),
      .match_o       (match),
      .sel_o         (sel),
      .any_match_o   (any_match),
      .multi_match_o (multi_match)
   );

   // Acceptance is blocked during reset, in FLUSH and on the cycle a flush is requested
   assign run_open = !rst_core && (state_q == ST_RUN) && !flush_req;
   assign free     = !out_valid_q || bus.out_ready_i;
   assign accept   = run_open && any_match && free;

   assign bus.unit_ready_o = accept ? (match & (NUM_UNITS'(1) << sel)) : '0;
   assign bus.out_valid_o  = out_valid_q;
   assign bus.out_data_o   = out_data_q;
   assign bus.out_unit_o   = out_unit_q;
   assign commit_token_o   = token_q;
   assign retire_o         = accept;
   assign order_err_o      = err_q;
   assign flush_ack        = flush_ack_q;

   // Next state: slot load/drain, token advance, stall tracking and flush sequencing
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_unit_d  = out_unit_q;
      token_d     = token_q;
      stall_d     = stall_q;
      err_d       = err_q;
      flush_ack_d = flush_ack_q;
      if (state_q == ST_RUN) begin
         if (flush_req) begin
            state_d     = ST_FLUSH;
            out_valid_d = 1'b0;
            token_d     = '0;
            stall_d     = '0;
            flush_ack_d = 1'b1;
         end else begin
            if (accept) begin
               out_valid_d = 1'b1;
               out_data_d  = bus.unit_data_i[sel*DATA_W +: DATA_W];
               out_unit_d  = sel;
               token_d     = token_q + TOKEN_W'(1);
               stall_d     = '0;
            end else if (free) begin
               out_valid_d = 1'b0;
            end
            if (!any_match && (|bus.unit_valid_i) && (stall_q != STALL_W'(STALL_LIMIT)))
               stall_d = stall_q + STALL_W'(1);
            if (multi_match || (stall_d == STALL_W'(STALL_LIMIT)))
               err_d = 1'b1;
         end
      end else begin
         out_valid_d = 1'b0;
         token_d     = '0;
         stall_d     = '0;
         if (!flush_req) begin
            state_d     = ST_RUN;
            flush_ack_d = 1'b0;
         end
      end
   end

   // State registers; reset overrides flush and any held slot
   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         state_q     <= ST_RUN;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_unit_q  <= '0;
         token_q     <= '0;
         stall_q     <= '0;
         err_q       <= 1'b0;
         flush_ack_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_unit_q  <= out_unit_d;
         token_q     <= token_d;
         stall_q     <= stall_d;
         err_q       <= err_d;
         flush_ack_q <= flush_ack_d;
      end
   end
endmodule

// File: tb/tb_hsv_core_commit_order.sv
// tb/tb_hsv_core_commit_order.sv - self-checking bench for the commit-order block
module tb_hsv_core_commit_order;
   import hsv_core_pkg::*;

   localparam int NU = 5;
   localparam int DW = 64;
   localparam int TW = 2;
   localparam int SL = 1024;
   localparam int RN = 64;

   logic          clk_core = 1'b0;
   logic          rst_core;
   logic          flush_req;
   logic          flush_ack;
   logic [TW-1:0] commit_token_o;
   logic          retire_o;
   logic          order_err_o;
   int            total = 0;
   int            bad = 0;

   hsv_core_commit_order_if #(.NUM_UNITS(NU), .DATA_W(DW), .TOKEN_W(TW)) bus ();

   hsv_core_commit_order #(
      .NUM_UNITS(NU), .DATA_W(DW), .TOKEN_W(TW), .STALL_LIMIT(SL)
   ) dut (
      .clk_core       (clk_core),
      .rst_core       (rst_core),
      .flush_req      (flush_req),
      .flush_ack      (flush_ack),
      .bus            (bus),
      .commit_token_o (commit_token_o),
      .retire_o       (retire_o),
      .order_err_o    (order_err_o)
   );

   always #5 clk_core = ~clk_core;

   task automatic cyc();
      @(posedge clk_core);
      #1;
   endtask

   task automatic mid();
      @(negedge clk_core);
   endtask

   task automatic clear_units();
      bus.unit_valid_i = '0;
      bus.unit_token_i = '0;
      bus.unit_data_i  = '0;
   endtask

   task automatic set_unit(input int u, input int tok, input logic [DW-1:0] d);
      bus.unit_valid_i[u]           = 1'b1;
      bus.unit_token_i[u*TW +: TW]  = TW'(tok);
      bus.unit_data_i[u*DW +: DW]   = d;
   endtask

   task automatic apply_reset();
      rst_core = 1'b1;
      flush_req = 1'b0;
      clear_units();
      bus.out_ready_i = 1'b1;
      cyc();
      cyc();
      rst_core = 1'b0;
   endtask

   task automatic test_reset();
      rst_core = 1'b1;
      flush_req = 1'b1;
      bus.out_ready_i = 1'b0;
      clear_units();
      set_unit(MEM, 0, 64'h1);
      cyc();
      cyc();
      mid();
      total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid_o); end
      total++; if (bus.out_data_o !== 64'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", bus.out_data_o); end
      total++; if (bus.out_unit_o !== 3'd0) begin bad++; $display("FAIL reset_out_unit: got %0d want 0", bus.out_unit_o); end
      total++; if (commit_token_o !== 2'd0) begin bad++; $display("FAIL reset_token: got %0d want 0", commit_token_o); end
      total++; if (flush_ack !== 1'b0) begin bad++; $display("FAIL reset_flush_ack: got %b want 0", flush_ack); end
      total++; if (order_err_o !== 1'b0) begin bad++; $display("FAIL reset_order_err: got %b want 0", order_err_o); end
      total++; if (retire_o !== 1'b0) begin bad++; $display("FAIL reset_retire: got %b want 0", retire_o); end
      total++; if (bus.unit_ready_o !== 5'b0) begin bad++; $display("FAIL reset_ready: got %b want 00000", bus.unit_ready_o); end
      rst_core = 1'b0;
      flush_req = 1'b0;
      clear_units();
      cyc();
   endtask

   task automatic test_single();
      apply_reset();
      set_unit(MEM, 0, 64'hA5);
      mid();
      total++; if (bus.unit_ready_o !== 5'b00100) begin bad++; $display("FAIL single_ready: got %b want 00100", bus.unit_ready_o); end
      total++; if (retire_o !== 1'b1) begin bad++; $display("FAIL single_retire: got %b want 1", retire_o); end
      cyc();
      clear_units();
      total++; if (bus.out_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", bus.out_valid_o); end
      total++; if (bus.out_data_o !== 64'hA5) begin bad++; $display("FAIL single_data: got %h want a5", bus.out_data_o); end
      total++; if (bus.out_unit_o !== 3'd2) begin bad++; $display("FAIL single_unit: got %0d want 2", bus.out_unit_o); end
      total++; if (commit_token_o !== 2'd1) begin bad++; $display("FAIL single_token: got %0d want 1", commit_token_o); end
      cyc();
      total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", bus.out_valid_o); end
   endtask

   task automatic test_priority_order();
      apply_reset();
      set_unit(ALU, 1, 64'h0D0);
      set_unit(CTRLSTATUS, 0, 64'h4D4);
      mid();
      total++; if (bus.unit_ready_o !== 5'b10000) begin bad++; $display("FAIL order_ready0: got %b want 10000", bus.unit_ready_o); end
      cyc();
      bus.unit_valid_i[CTRLSTATUS] = 1'b0;
      total++; if (bus.out_unit_o !== 3'd4) begin bad++; $display("FAIL order_unit0: got %0d want 4", bus.out_unit_o); end
      total++; if (commit_token_o !== 2'd1) begin bad++; $display("FAIL order_token0: got %0d want 1", commit_token_o); end
      mid();
      total++; if (bus.unit_ready_o !== 5'b00001) begin bad++; $display("FAIL order_ready1: got %b want 00001", bus.unit_ready_o); end
      cyc();
      clear_units();
      total++; if (bus.out_unit_o !== 3'd0) begin bad++; $display("FAIL order_unit1: got %0d want 0", bus.out_unit_o); end
      total++; if (bus.out_data_o !== 64'h0D0) begin bad++; $display("FAIL order_data1: got %h want 0d0", bus.out_data_o); end
      total++; if (commit_token_o !== 2'd2) begin bad++; $display("FAIL order_token1: got %0d want 2", commit_token_o); end
   endtask

   task automatic test_back_to_back();
      int u;
      logic [DW-1:0] d;
      logic [NU-1:0] er;
      apply_reset();
      for (int n = 0; n < 7; n++) begin
         u = $urandom_range(0, NU - 1);
         d = {$urandom, $urandom};
         er = NU'(1) << u;
         clear_units();
         set_unit(u, n % 4, d);
         mid();
         total++; if (bus.unit_ready_o !== er) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want %b", n, bus.unit_ready_o, er); end
         total++; if (retire_o !== 1'b1) begin bad++; $display("FAIL b2b_retire[%0d]: got %b want 1", n, retire_o); end
         cyc();
         total++; if (bus.out_valid_o !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", n, bus.out_valid_o); end
         total++; if (bus.out_data_o !== d) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", n, bus.out_data_o, d); end
         total++; if (bus.out_unit_o !== 3'(u)) begin bad++; $display("FAIL b2b_unit[%0d]: got %0d want %0d", n, bus.out_unit_o, u); end
         total++; if (commit_token_o !== TW'(n + 1)) begin bad++; $display("FAIL b2b_token[%0d]: got %0d want %0d", n, commit_token_o, (n + 1) % 4); end
      end
      clear_units();
   endtask

   task automatic test_backpressure();
      apply_reset();
      set_unit(FOO, 0, 64'h1111);
      cyc();
      clear_units();
      bus.out_ready_i = 1'b0;
      set_unit(BRANCH, 1, 64'h3333);
      for (int k = 0; k < 5; k++) begin
         mid();
         total++; if (bus.unit_ready_o !== 5'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 00000", k, bus.unit_ready_o); end
         total++; if (retire_o !== 1'b0) begin bad++; $display("FAIL bp_retire[%0d]: got %b want 0", k, retire_o); end
         cyc();
         total++; if (bus.out_data_o !== 64'h1111 || bus.out_valid_o !== 1'b1) begin bad++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/1111", k, bus.out_valid_o, bus.out_data_o); end
      end
      bus.out_ready_i = 1'b1;
      mid();
      total++; if (bus.unit_ready_o !== 5'b01000) begin bad++; $display("FAIL bp_release_ready: got %b want 01000", bus.unit_ready_o); end
      cyc();
      clear_units();
      total++; if (bus.out_data_o !== 64'h3333) begin bad++; $display("FAIL bp_release_data: got %h want 3333", bus.out_data_o); end
      total++; if (commit_token_o !== 2'd2) begin bad++; $display("FAIL bp_release_token: got %0d want 2", commit_token_o); end
   endtask

   task automatic test_flush();
      apply_reset();
      set_unit(ALU, 0, 64'hA);
      cyc();
      clear_units();
      set_unit(ALU, 1, 64'hB);
      cyc();
      clear_units();
      bus.out_ready_i = 1'b0;
      set_unit(MEM, 2, 64'hC);
      flush_req = 1'b1;
      mid();
      total++; if (bus.unit_ready_o !== 5'b0) begin bad++; $display("FAIL flush_entry_ready: got %b want 00000", bus.unit_ready_o); end
      total++; if (retire_o !== 1'b0) begin bad++; $display("FAIL flush_entry_retire: got %b want 0", retire_o); end
      cyc();
      total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", bus.out_valid_o); end
      total++; if (commit_token_o !== 2'd0) begin bad++; $display("FAIL flush_token: got %0d want 0", commit_token_o); end
      total++; if (flush_ack !== 1'b1) begin bad++; $display("FAIL flush_ack_set: got %b want 1", flush_ack); end
      cyc();
      flush_req = 1'b0;
      clear_units();
      set_unit(MEM, 0, 64'h2E);
      bus.out_ready_i = 1'b1;
      mid();
      total++; if (bus.unit_ready_o !== 5'b0) begin bad++; $display("FAIL flush_exit_ready: got %b want 00000", bus.unit_ready_o); end
      cyc();
      total++; if (flush_ack !== 1'b0) begin bad++; $display("FAIL flush_ack_clear: got %b want 0", flush_ack); end
      mid();
      total++; if (bus.unit_ready_o !== 5'b00100) begin bad++; $display("FAIL flush_resume_ready: got %b want 00100", bus.unit_ready_o); end
      cyc();
      clear_units();
      total++; if (bus.out_data_o !== 64'h2E || commit_token_o !== 2'd1) begin bad++; $display("FAIL flush_resume: got %h/%0d want 2e/1", bus.out_data_o, commit_token_o); end
      flush_req = 1'b1;
      cyc();
      rst_core = 1'b1;
      cyc();
      total++; if (flush_ack !== 1'b0 || bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL flush_reset_prio: got %b/%b want 0/0", flush_ack, bus.out_valid_o); end
      rst_core = 1'b0;
      flush_req = 1'b0;
   endtask

   task automatic test_multi_match();
      apply_reset();
      set_unit(FOO, 0, 64'h11);
      set_unit(BRANCH, 0, 64'h33);
      mid();
      total++; if (bus.unit_ready_o !== 5'b00010) begin bad++; $display("FAIL multi_ready: got %b want 00010", bus.unit_ready_o); end
      total++; if (order_err_o !== 1'b0) begin bad++; $display("FAIL multi_err_before: got %b want 0", order_err_o); end
      cyc();
      clear_units();
      total++; if (order_err_o !== 1'b1) begin bad++; $display("FAIL multi_err: got %b want 1", order_err_o); end
      total++; if (bus.out_unit_o !== 3'd1 || bus.out_data_o !== 64'h11) begin bad++; $display("FAIL multi_sel: got %0d/%h want 1/11", bus.out_unit_o, bus.out_data_o); end
   endtask

   task automatic test_stall();
      apply_reset();
      set_unit(MEM, 1, 64'h77);
      repeat (SL - 1) cyc();
      total++; if (order_err_o !== 1'b0) begin bad++; $display("FAIL stall_below_limit: got %b want 0", order_err_o); end
      cyc();
      total++; if (order_err_o !== 1'b1) begin bad++; $display("FAIL stall_at_limit: got %b want 1", order_err_o); end
      clear_units();
      set_unit(ALU, 0, 64'h5);
      cyc();
      clear_units();
      cyc();
      total++; if (order_err_o !== 1'b1) begin bad++; $display("FAIL stall_sticky: got %b want 1", order_err_o); end
      apply_reset();
      total++; if (order_err_o !== 1'b0) begin bad++; $display("FAIL stall_reset_clear: got %b want 0", order_err_o); end
   endtask

   task automatic test_random();
      int pu[RN];
      logic [DW-1:0] pd[RN];
      int uq[NU][$];
      int sb[$];
      int acc;
      int cycles;
      logic [NU-1:0] exp_ready;
      apply_reset();
      for (int n = 0; n < RN; n++) begin
         pu[n] = $urandom_range(0, NU - 1);
         pd[n] = {$urandom, $urandom};
         uq[pu[n]].push_back(n);
      end
      acc = 0;
      cycles = 0;
      while ((acc < RN || sb.size() != 0) && cycles < 4000) begin
         clear_units();
         for (int u = 0; u < NU; u++)
            if (uq[u].size() != 0 && uq[u][0] < acc + 4 && $urandom_range(0, 3) != 0)
               set_unit(u, uq[u][0] % 4, pd[uq[u][0]]);
         bus.out_ready_i = ($urandom_range(0, 3) != 0);
         mid();
         exp_ready = '0;
         if (acc < RN && (sb.size() == 0 || bus.out_ready_i) && bus.unit_valid_i[pu[acc]])
            exp_ready[pu[acc]] = 1'b1;
         total++; if (bus.unit_ready_o !== exp_ready) begin bad++; $display("FAIL rnd_ready[c%0d]: got %b want %b", cycles, bus.unit_ready_o, exp_ready); end
         total++; if (retire_o !== (|exp_ready)) begin bad++; $display("FAIL rnd_retire[c%0d]: got %b want %b", cycles, retire_o, |exp_ready); end
         total++; if (bus.out_valid_o !== (sb.size() != 0)) begin bad++; $display("FAIL rnd_valid[c%0d]: got %b want %b", cycles, bus.out_valid_o, sb.size() != 0); end
         if (sb.size() != 0) begin
            total++; if (bus.out_data_o !== pd[sb[0]] || bus.out_unit_o !== 3'(pu[sb[0]])) begin bad++; $display("FAIL rnd_slot[c%0d]: got %h/%0d want %h/%0d", cycles, bus.out_data_o, bus.out_unit_o, pd[sb[0]], pu[sb[0]]); end
         end
         @(posedge clk_core);
         if (sb.size() != 0 && bus.out_ready_i) void'(sb.pop_front());
         if (exp_ready != '0) begin
            sb.push_back(acc);
            void'(uq[pu[acc]].pop_front());
            acc++;
         end
         #1;
         cycles++;
      end
      total++; if (cycles >= 4000) begin bad++; $display("FAIL rnd_timeout: got %0d accepted want %0d", acc, RN); end
      total++; if (commit_token_o !== TW'(RN)) begin bad++; $display("FAIL rnd_final_token: got %0d want %0d", commit_token_o, RN % 4); end
      clear_units();
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority_order();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_multi_match();
      test_stall();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
